// File: rtl/instr_fetch.sv
// instr_fetch: RV32 fetch stage owning the PC, a single-outstanding imem read channel and a small instruction FIFO.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirect targets set a sticky misalign flag and halt fetch.
module instr_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  misalign
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   fetch_pc;
    logic [DATA_WIDTH-1:0]   pend_pc;
    logic [DATA_WIDTH-1:0]   target_pc;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_nxt;
    logic [IDX_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   fifo_instr     [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_instr_nxt [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_pc        [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_pc_nxt    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_vld;
    logic [FIFO_DEPTH-1:0]   fifo_vld_nxt;
    logic                    outstanding;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    misalign_q;

    assign target_pc   = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign outstanding = (state != IDLE);
    assign accept      = imem_req & imem_ready;
    assign push        = (state == WAIT) & imem_rvalid & ~redirect;
    assign pop         = fifo_vld[0] & instr_ready & ~redirect;

    assign imem_addr   = fetch_pc;
    assign instr_valid = fifo_vld[0];
    assign instr       = fifo_instr[0];
    assign instr_pc    = fifo_pc[0];
    assign misalign    = misalign_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a response arriving together with a redirect is simply dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: if (imem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output: request only when a FIFO slot is free for the response
    always_comb begin
        imem_req = 1'b0;
        if (en && !redirect && !misalign_q && !outstanding && (count < CNT_W'(FIFO_DEPTH))) begin
            imem_req = 1'b1;
        end
    end

    // PC tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
        end else if (redirect) begin
            fetch_pc <= target_pc;
        end else if (accept) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + DATA_WIDTH'(4);
        end
    end

    // Shift-register FIFO: entry 0 is the head so outputs come straight from flops; empty slots hold zero
    always_comb begin
        fifo_instr_nxt = fifo_instr;
        fifo_pc_nxt    = fifo_pc;
        fifo_vld_nxt   = fifo_vld;
        count_nxt      = count;
        wr_idx         = pop ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);
        if (redirect) begin
            fifo_instr_nxt = '{default: '0};
            fifo_pc_nxt    = '{default: '0};
            fifo_vld_nxt   = '0;
            count_nxt      = '0;
        end else begin
            if (pop) begin
                for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
                    fifo_instr_nxt[i] = fifo_instr[i + 1];
                    fifo_pc_nxt[i]    = fifo_pc[i + 1];
                end
                fifo_instr_nxt[FIFO_DEPTH-1] = '0;
                fifo_pc_nxt[FIFO_DEPTH-1]    = '0;
                fifo_vld_nxt                 = fifo_vld >> 1;
            end
            if (push) begin
                fifo_instr_nxt[wr_idx] = imem_rdata;
                fifo_pc_nxt[wr_idx]    = pend_pc;
                fifo_vld_nxt[wr_idx]   = 1'b1;
            end
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_instr <= '{default: '0};
            fifo_pc    <= '{default: '0};
            fifo_vld   <= '0;
            count      <= '0;
        end else begin
            fifo_instr <= fifo_instr_nxt;
            fifo_pc    <= fifo_pc_nxt;
            fifo_vld   <= fifo_vld_nxt;
            count      <= count_nxt;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Sticky trap flag; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    logic unused_lsb;
    assign misalign_q = 1'b0;
    assign unused_lsb = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle vector table for steady-state fetch/backpressure,
// hand sequences for redirect corner cases, and a scoreboard for every consumed instruction.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        irdy;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl [16];
    int          n_chk;
    int          n_fail;
    logic [63:0] sb [$];
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic [31:0] s_req;
    logic [31:0] s_addr;
    logic [31:0] s_iv;
    logic [31:0] s_pc;
    logic [31:0] s_ins;
    logic [31:0] s_mis;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs and memory response, sample, score pops, model memory acceptance
    task automatic cyc(input logic e, input logic ir, input logic rd, input logic [31:0] rp);
        logic [63:0] exp;
        en          = e;
        instr_ready = ir;
        redirect    = rd;
        redirect_pc = rp;
        imem_rvalid = (mem_cnt == 1);
        imem_rdata  = (mem_cnt == 1) ? mdata(mem_addr) : 32'h0;
        #1;
        s_req  = 32'(imem_req);
        s_addr = imem_addr;
        s_iv   = 32'(instr_valid);
        s_pc   = instr_pc;
        s_ins  = instr;
        s_mis  = 32'(misalign);
        if (instr_valid && ir && !rd) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_empty: popped pc %h with nothing expected", s_pc);
            end else begin
                exp = sb.pop_front();
                chk("sb_instr", s_ins, exp[63:32]);
                chk("sb_pc", s_pc, exp[31:0]);
            end
        end
        if (rd) sb.delete();
        if (mem_cnt > 0) mem_cnt--;
        if (imem_req && imem_ready) begin
            mem_addr = imem_addr;
            mem_cnt  = mem_lat;
            sb.push_back({mdata(imem_addr), imem_addr});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        //            en    irdy  req   addr    iv    pc
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'd4,  1'b0, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'd8,  1'b0, 32'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'd12, 1'b0, 32'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'd16, 1'b0, 32'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd12};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'd20, 1'b1, 32'd12};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd16};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'd24, 1'b0, 32'd0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd20};

        n_chk       = 0;
        n_fail      = 0;
        mem_lat     = 1;
        mem_cnt     = 0;
        mem_addr    = 32'h0;
        rst         = 1'b1;
        en          = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_iv", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        rst = 1'b0;

        // Steady fetch with 1-cycle memory, then downstream stall and release
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].en, tbl[i].irdy, 1'b0, 32'h0);
            chk("tbl_req", s_req, 32'(tbl[i].req));
            chk("tbl_addr", s_addr, tbl[i].addr);
            chk("tbl_iv", s_iv, 32'(tbl[i].iv));
            chk("tbl_pc", s_pc, tbl[i].pc);
            if (!tbl[i].iv) chk("tbl_empty_instr", s_ins, 32'h0);
        end
        idle(3);

        // Redirect while a 2-cycle read is in flight: response dropped, fetch restarts at 0x100
        mem_lat = 2;
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("a_req", s_req, 32'd1);
        chk("a_addr", s_addr, 32'd28);
        cyc(1'b1, 1'b1, 1'b1, 32'h100);
        chk("a_wait_req", s_req, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("drop_req", s_req, 32'd0);
        chk("drop_addr", s_addr, 32'h100);
        chk("drop_iv", s_iv, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_req", s_req, 32'd1);
        chk("redir_addr", s_addr, 32'h100);
        chk("redir_iv", s_iv, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("redir_iv2", s_iv, 32'd1);
        chk("redir_pc", s_pc, 32'h100);
        idle(2);
        mem_lat = 1;

        // Redirect coinciding with rvalid and a pop: nothing pushed, FIFO empty next cycle
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("b_addr0", s_addr, 32'h104);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("b_iv0", s_iv, 32'd1);
        chk("b_pc0", s_pc, 32'h104);
        chk("b_addr1", s_addr, 32'h108);
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        chk("b_pre_iv", s_iv, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("b_post_iv", s_iv, 32'd0);
        chk("b_post_instr", s_ins, 32'h0);
        chk("b_post_req", s_req, 32'd1);
        chk("b_post_addr", s_addr, 32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("b_pc", s_pc, 32'h200);
        idle(2);

        // Address wrap from 0xFFFF_FFFC to 0
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("c_redir_req", s_req, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("c_req", s_req, 32'd1);
        chk("c_addr", s_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c_wrap_addr", s_addr, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c_pc", s_pc, 32'hFFFF_FFFC);
        idle(1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("c_next_req", s_req, 32'd1);
        chk("c_next_addr", s_addr, 32'h0);
        idle(3);

        // Misaligned redirect target
        chk("d_mis_before", s_mis, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'h102);
        chk("d_redir_req", s_req, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("d_mis", s_mis, 32'd1);
        chk("d_req", s_req, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("d_mis_hold", s_mis, 32'd1);
        chk("d_req_hold", s_req, 32'd0);
`else
        chk("d_mis", s_mis, 32'd0);
        chk("d_req", s_req, 32'd1);
        chk("d_addr", s_addr, 32'h100);
        idle(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
